// File: rtl/sa_result_collector.sv
// Drain-side collector for the systolic array: captures one result column per
// valid shift, rebuilds the X_R x W_C matrix and holds it until acknowledged.
module sa_result_collector #(
  parameter int D_W = 8,
  parameter int X_R = 16,
  parameter int W_C = 16
) (
  input  logic                     I_CLK,
  input  logic                     I_ASYN_RSTN,
  input  logic                     I_SYNC_RSTN,
  input  logic                     I_START,
  input  logic                     I_VALID,
  input  logic [X_R*D_W-1:0]       I_RES_VECTOR,
  input  logic                     I_ACK,
  output logic [X_R*W_C*D_W-1:0]   O_MATRIX,
  output logic [15:0]              O_COUNT,
  output logic                     O_BUSY,
  output logic                     O_FULL,
  output logic                     O_DONE,
  output logic                     O_OVERRUN,
  output logic [1:0]               O_STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            capture;
  logic            last;
  logic            arm;
  logic [15:0]     count;
  logic [15:0]     wr_col;
  logic            done;
  logic            overrun;
  logic [D_W-1:0]  mat [X_R][W_C];

  // I_VALID is a push-only strobe with no backpressure: a column is taken on
  // every edge it is high in S_COLLECT and dropped otherwise (flagged in S_FULL).
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    last       = 1'b0;
    arm        = 1'b0;
    case (state)
      S_IDLE: begin
        if (I_START) begin
          next_state = S_COLLECT;
          arm        = 1'b1;
        end
      end
      S_COLLECT: begin
        if (I_VALID) begin
          capture = 1'b1;
          if (count == 16'(W_C - 1)) begin
            last       = 1'b1;
            next_state = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (I_ACK) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN)      state <= S_IDLE;
    else if (!I_SYNC_RSTN) state <= S_IDLE;
    else                   state <= next_state;
  end

  // First column out of the array is the rightmost one, so fill right to left.
  assign wr_col = 16'(W_C - 1) - count;

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < X_R; i++)
        for (int j = 0; j < W_C; j++)
          mat[i][j] <= '0;
    end else if (!I_SYNC_RSTN) begin
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < X_R; i++)
        for (int j = 0; j < W_C; j++)
          mat[i][j] <= '0;
    end else begin
      done <= last;
      if (arm) begin
        count   <= '0;
        overrun <= 1'b0;
      end
      if (state == S_FULL && I_VALID) overrun <= 1'b1;
      if (capture) begin
        count <= count + 16'd1;
        for (int i = 0; i < X_R; i++)
          for (int j = 0; j < W_C; j++)
            if (wr_col == 16'(j)) mat[i][j] <= I_RES_VECTOR[i*D_W +: D_W];
      end
    end
  end

  for (genvar r = 0; r < X_R; r++) begin : g_row
    for (genvar c = 0; c < W_C; c++) begin : g_col
      assign O_MATRIX[(r*W_C+c)*D_W +: D_W] = mat[r][c];
    end
  end

  assign O_COUNT   = count;
  assign O_BUSY    = (state == S_COLLECT);
  assign O_FULL    = (state == S_FULL);
  assign O_DONE    = done;
  assign O_OVERRUN = overrun;
  assign O_STATE   = state;

endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: directed scenarios plus random traffic,
// checked against a column-queue reference model of the collector.
module tb_sa_result_collector;
  localparam int D_W = 8;
  localparam int X_R = 16;
  localparam int W_C = 16;
  localparam int P_IDLE = 0, P_COLLECT = 1, P_FULL = 2;

  logic                   clk;
  logic                   asyn_rstn, sync_rstn, start, valid, ack;
  logic [X_R*D_W-1:0]     res_vector;
  logic [X_R*W_C*D_W-1:0] matrix;
  logic [15:0]            count;
  logic                   busy, full, done, overrun;
  logic [1:0]             state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int phase;
  int m_count;
  int m_done;
  int m_overrun;
  int exp_mat [X_R][W_C];
  logic [X_R*D_W-1:0] col_q[$];

  sa_result_collector #(.D_W(D_W), .X_R(X_R), .W_C(W_C)) dut (
    .I_CLK(clk), .I_ASYN_RSTN(asyn_rstn), .I_SYNC_RSTN(sync_rstn),
    .I_START(start), .I_VALID(valid), .I_RES_VECTOR(res_vector), .I_ACK(ack),
    .O_MATRIX(matrix), .O_COUNT(count), .O_BUSY(busy), .O_FULL(full),
    .O_DONE(done), .O_OVERRUN(overrun), .O_STATE(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase     = P_IDLE;
    m_count   = 0;
    m_done    = 0;
    m_overrun = 0;
    col_q.delete();
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++)
        exp_mat[r][c] = 0;
  endtask

  // k-th column drained lands in matrix column W_C-1-k; older columns persist.
  task automatic model_step(input logic s, input logic v, input logic a,
                            input logic [X_R*D_W-1:0] vec, input logic srst);
    m_done = 0;
    if (!srst) begin
      model_reset();
      return;
    end
    case (phase)
      P_IDLE: if (s) begin
        phase = P_COLLECT; m_count = 0; m_overrun = 0; col_q.delete();
      end
      P_COLLECT: if (v) begin
        col_q.push_back(vec);
        m_count = col_q.size();
        for (int r = 0; r < X_R; r++)
          exp_mat[r][W_C - col_q.size()] = int'(vec[r*D_W +: D_W]);
        if (m_count == W_C) begin
          phase = P_FULL; m_done = 1;
        end
      end
      default: begin
        if (v) m_overrun = 1;
        if (a) phase = P_IDLE;
      end
    endcase
  endtask

  task automatic check_status();
    check("count", 32'(count), 32'(m_count));
    check("busy", 32'(busy), 32'(phase == P_COLLECT));
    check("full", 32'(full), 32'(phase == P_FULL));
    check("done", 32'(done), 32'(m_done));
    check("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  task automatic check_matrix(input string tag);
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++)
        check(tag, 32'(matrix[(r*W_C+c)*D_W +: D_W]), 32'(exp_mat[r][c]));
  endtask

  // Inputs change at negedge; the model advances with the posedge; outputs are
  // checked at the following negedge.
  task automatic drive(input logic s, input logic v, input logic a,
                       input logic [X_R*D_W-1:0] vec, input logic srst);
    start = s; valid = v; ack = a; res_vector = vec; sync_rstn = srst;
    @(posedge clk);
    model_step(s, v, a, vec, srst);
    @(negedge clk);
    check_status();
  endtask

  function automatic logic [X_R*D_W-1:0] basic_col(input int k);
    logic [X_R*D_W-1:0] v;
    for (int r = 0; r < X_R; r++) v[r*D_W +: D_W] = D_W'(16*r + 15 - k);
    return v;
  endfunction

  function automatic logic [X_R*D_W-1:0] rand_col();
    logic [X_R*D_W-1:0] v;
    for (int r = 0; r < X_R; r++) v[r*D_W +: D_W] = D_W'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic check_literal(input string tag);
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++)
        check(tag, 32'(matrix[(r*W_C+c)*D_W +: D_W]), 32'(16*r + c));
  endtask

  int done_seen;
  logic [X_R*D_W-1:0] ones;

  initial begin
    ones = '1;
    asyn_rstn = 1'b0; sync_rstn = 1'b1; start = 1'b0; valid = 1'b0; ack = 1'b0;
    res_vector = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_status();
    check_matrix("reset_matrix");
    asyn_rstn = 1'b1;

    // Basic back-to-back drain
    drive(1, 0, 0, '0, 1);
    for (int k = 0; k < W_C; k++) drive(0, 1, 0, basic_col(k), 1);
    check_matrix("basic_model");
    check_literal("basic_literal");

    // Overrun while full: data dropped, flag sticky
    repeat (3) drive(0, 1, 0, ones, 1);
    drive(0, 0, 0, '0, 1);
    check_matrix("overrun_hold");

    // Start coinciding with ack is ignored; re-armed on the next cycle
    drive(1, 0, 1, '0, 1);
    check("start_ack_idle", 32'(busy), 32'(0));
    drive(1, 0, 0, '0, 1);
    check("rearm_count", 32'(count), 32'(0));

    // Gapped drain with stray starts mid-collection
    done_seen = 0;
    for (int k = 0; k < W_C; k++) begin
      drive(k == 3, 1, 0, basic_col(k), 1);
      if (done) done_seen++;
      if (k < W_C - 1) begin
        for (int g = 0; g < ((k % 2) ? 3 : 1); g++) begin
          drive($urandom_range(0, 1), 0, $urandom_range(0, 1), rand_col(), 1);
          if (done) done_seen++;
        end
      end
    end
    drive(0, 0, 0, '0, 1);
    if (done) done_seen++;
    check("gapped_done_once", 32'(done_seen), 32'(1));
    check_literal("gapped_literal");
    drive(0, 0, 1, '0, 1);

    // Valid on the start edge is not captured
    drive(1, 1, 0, rand_col(), 1);
    drive(0, 1, 0, rand_col(), 1);
    drive(0, 0, 1, '0, 1);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, rand_col(), 1);

    // Async reset after 5 columns
    asyn_rstn = 1'b0;
    #1;
    model_reset();
    check_status();
    check_matrix("arst_matrix");
    @(negedge clk);
    asyn_rstn = 1'b1;
    drive(0, 0, 0, '0, 1);

    // Sync reset after 5 columns, with competing inputs
    drive(1, 0, 0, '0, 1);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, rand_col(), 1);
    drive(1, 1, 1, rand_col(), 0);
    check_matrix("srst_matrix");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, rand_col(), $urandom_range(0, 149) != 0);
      if (n % 60 == 59) check_matrix("rand_matrix");
    end
    check_matrix("final_matrix");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sa_result_collector.md
# sa_result_collector

Drain-side companion of the systolic-array input feeder. After a matrix multiply, the array shifts its accumulated results out of its right edge one column per shift. This block captures those columns, reassembles the full X_R×W_C result matrix in a register bank, and holds it for a downstream consumer until acknowledged. It sits between the PE array's output edge and the next MHA stage (softmax or the next matmul input).

## Interface
- D_W, 8, bit width of each result element
- X_R, 16, rows of result matrix (one per PE row)
- W_C, 16, columns of result matrix (number of shifts to drain)
- I_CLK  in  1  clock, all state updates on rising edge
- I_ASYN_RSTN  in  1  asynchronous, active-low reset
- I_SYNC_RSTN  in  1  synchronous, active-low reset; same effect as async reset, applied at the clock edge
- I_START  in  1  arm collection for one result matrix
- I_VALID  in  1  array presents a valid column on I_RES_VECTOR this cycle
- I_RES_VECTOR  in  X_R×D_W  column leaving the array's right edge, element i from PE row i
- I_ACK  in  1  consumer has taken O_MATRIX; frees the buffer
- O_MATRIX  out  X_R×W_C×D_W  assembled result, registered
- O_COUNT  out  16  columns captured so far in current collection
- O_BUSY  out  1  high in S_COLLECT
- O_FULL  out  1  high in S_FULL, O_MATRIX complete and stable
- O_DONE  out  1  one-cycle pulse on entry to S_FULL
- O_OVERRUN  out  1  sticky: I_VALID seen while S_FULL

## Operation
- States: S_IDLE, S_COLLECT, S_FULL. Reset state S_IDLE.
- Reset (either): state S_IDLE, O_COUNT=0, every O_MATRIX element 0, O_DONE=0, O_OVERRUN=0, O_BUSY=0, O_FULL=0. Sync reset has priority over all other inputs.
- S_IDLE: I_START=1 → S_COLLECT, O_COUNT←0, O_OVERRUN←0. I_VALID ignored. O_MATRIX retains previous contents.
- S_COLLECT: each cycle with I_VALID=1, for all i: O_MATRIX[i][W_C-1-O_COUNT] ← I_RES_VECTOR[i]; O_COUNT increments. The first column out is column W_C-1 (rightmost PE column), the last is column 0. I_START is ignored.
- The capture with O_COUNT=W_C-1 is the last: same edge sets O_COUNT=W_C, state S_FULL, O_DONE=1.
- S_FULL: O_MATRIX frozen. I_VALID=1 sets O_OVERRUN and data is discarded. I_ACK=1 → S_IDLE, O_COUNT unchanged until next start. I_START in S_FULL is ignored, including when it coincides with I_ACK; the consumer must re-assert it in S_IDLE.
- I_ACK outside S_FULL is ignored.
- I_VALID gaps in S_COLLECT are allowed: O_COUNT and O_MATRIX hold.
- No arithmetic on data; elements are stored bit-exact. O_COUNT never exceeds W_C.

## Timing
- I_START sampled at edge k in S_IDLE → O_BUSY=1 after k. I_VALID at edge k is not captured; the first capture is at edge k+1 or later.
- Capture latency: column sampled at edge e is visible on O_MATRIX after e.
- Minimum collection: W_C consecutive I_VALID cycles → O_FULL/O_DONE rise after the W_C-th capture edge; O_DONE falls after the next edge.
- I_ACK at edge a → O_FULL=0, state S_IDLE after a. Earliest next I_START at edge a+1.
- Async reset mid-collection: immediate return to reset values. The partially written matrix is cleared.

## Test plan
- Reset: assert I_ASYN_RSTN=0 mid-collection after 5 columns → all outputs 0, state S_IDLE. Repeat with I_SYNC_RSTN → same at next edge.
- Basic drain (X_R=W_C=16): I_START, then 16 back-to-back I_VALID with column c carrying value 16·row+(15−c) → O_MATRIX[r][c]=16r+c, O_DONE one cycle after 16th capture, O_COUNT=16.
- Gapped valid: I_VALID on alternate cycles with 3-cycle stalls → identical matrix to basic drain. O_BUSY held throughout, O_DONE exactly once.
- Overrun and hold: in S_FULL drive I_VALID with 0xFF → O_OVERRUN=1, O_MATRIX unchanged. The next I_START clears O_OVERRUN.
- Start/ack interplay: I_START during S_COLLECT ignored (count continues). I_START with I_ACK in S_FULL → S_IDLE, not S_COLLECT. I_START next cycle → S_COLLECT, O_COUNT=0.
- Start-edge valid: I_VALID high on the same edge as I_START → not captured. O_COUNT=0 after that edge, 1 after the next.
